rv32_mem_access: RTL and testbench

- Memory stage of the RV32 pipeline, directly downstream of the execute stage.
- Consumes the execute stage's registered memory-control and data outputs and performs loads and stores over a single-outstanding request/ready data bus.
- Holds the upstream pipeline with stall_out until each access completes.
- Formats load data by lane, extends it, and registers rd/value for writeback.

---
 rtl/rv32_mem_pkg.sv | 24 ++
 rtl/rv32_mem_align.sv | 45 ++++
 rtl/rv32_mem_access.sv | 194 +++++++++++++++++++
 tb/tb_rv32_mem_access.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 memory stage: access widths, FSM states and
// the request context captured when a bus access is issued.
package rv32_mem_pkg;

  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_e;

  typedef struct packed {
    logic        read;
    logic [1:0]  width;
    logic        zero_ext;
    logic [4:0]  rd;
    logic        rd_write;
    logic [31:0] result;
  } mem_req_t;

endpackage

// File: rtl/rv32_mem_align.sv
// Combinational lane logic: misalignment detection, store strobes/replication
// and load lane selection with sign or zero extension.
module rv32_mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic        zero_ext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic        misalign_o,
  output logic [3:0]  mask_o,
  output logic [31:0] store_value_o,
  output logic [31:0] load_value_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = load_data_i[{off_i, 3'b000} +: 8];
  assign half_lane = load_data_i[{off_i[1], 4'b0000} +: 16];

  // Width 3 falls into the default arm and behaves as a word access.
  always_comb begin
    misalign_o    = 1'b0;
    mask_o        = 4'b1111;
    store_value_o = store_data_i;
    load_value_o  = load_data_i;
    case (width_i)
      RV32_MEM_WIDTH_BYTE: begin
        mask_o        = 4'b0001 << off_i;
        store_value_o = {4{store_data_i[7:0]}};
        load_value_o  = zero_ext_i ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      RV32_MEM_WIDTH_HALF: begin
        misalign_o    = off_i[0];
        mask_o        = 4'b0011 << off_i;
        store_value_o = {2{store_data_i[15:0]}};
        load_value_o  = zero_ext_i ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: misalign_o = |off_i;
    endcase
  end

endmodule

// File: rtl/rv32_mem_access.sv
// RV32 memory stage: issues one load/store at a time on a request/ready bus,
// stalls upstream until it completes and registers the writeback result.
module rv32_mem_access
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic        mem_fence_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out
);

  mem_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        squash_q, squash_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wval_q, wval_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_write_q, rd_write_d, misaligned_q, misaligned_d;
  logic [31:0] rd_value_q, rd_value_d;

  logic        access, misalign, misalign_access, idle;
  logic [1:0]  al_width, al_off;
  logic        al_zext;
  logic [3:0]  al_mask;
  logic [31:0] al_store, al_load, req_value;

  assign idle            = (state_q == IDLE);
  assign access          = (mem_read_in | mem_write_in) & ~mem_fence_in & ~flush_in;
  assign misalign_access = access & misalign;

  // Lane logic sees the live instruction while idle and the captured request afterwards.
  assign al_width  = idle ? mem_width_in       : req_q.width;
  assign al_zext   = idle ? mem_zero_extend_in : req_q.zero_ext;
  assign al_off    = idle ? result_in[1:0]     : req_q.result[1:0];
  assign req_value = req_q.read ? al_load : req_q.result;

  rv32_mem_align u_align (
    .width_i       (al_width),
    .zero_ext_i    (al_zext),
    .off_i         (al_off),
    .store_data_i  (rs2_value_in),
    .load_data_i   (data_read_value_in),
    .misalign_o    (misalign),
    .mask_o        (al_mask),
    .store_value_o (al_store),
    .load_value_o  (al_load)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    squash_d     = squash_q;
    hold_d       = hold_q;
    addr_d       = addr_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    mask_d       = mask_q;
    wval_d       = wval_q;
    rd_d         = rd_q;
    rd_write_d   = rd_write_q;
    rd_value_d   = rd_value_q;
    misaligned_d = 1'b0;
    stall_out    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_out = access & ~misalign;
        if (!stall_in) begin
          if (access && !misalign) begin
            state_d        = REQ;
            squash_d       = 1'b0;
            req_d.read     = mem_read_in;
            req_d.width    = mem_width_in;
            req_d.zero_ext = mem_zero_extend_in;
            req_d.rd       = rd_in;
            req_d.rd_write = rd_write_in;
            req_d.result   = result_in;
            addr_d         = {result_in[31:2], 2'b00};
            rd_req_d       = mem_read_in;
            wr_req_d       = mem_write_in;
            mask_d         = al_mask;
            wval_d         = al_store;
          end else begin
            rd_d         = rd_in;
            rd_write_d   = rd_write_in & ~flush_in & ~misalign_access;
            rd_value_d   = result_in;
            misaligned_d = misalign_access;
          end
        end
      end
      REQ: begin
        stall_out = ~data_ready_in | stall_in;
        squash_d  = squash_q | flush_in;
        if (data_ready_in) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          addr_d   = '0;
          mask_d   = '0;
          wval_d   = '0;
          if (stall_in) begin
            state_d = DONE;
            hold_d  = req_value;
          end else begin
            state_d    = IDLE;
            squash_d   = 1'b0;
            rd_d       = req_q.rd;
            rd_write_d = req_q.rd_write & ~(squash_q | flush_in);
            rd_value_d = req_value;
          end
        end
      end
      DONE: begin
        stall_out = stall_in;
        squash_d  = squash_q | flush_in;
        if (!stall_in) begin
          state_d    = IDLE;
          squash_d   = 1'b0;
          rd_d       = req_q.rd;
          rd_write_d = req_q.rd_write & ~(squash_q | flush_in);
          rd_value_d = hold_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      squash_q     <= 1'b0;
      hold_q       <= '0;
      addr_q       <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      mask_q       <= '0;
      wval_q       <= '0;
      rd_q         <= '0;
      rd_write_q   <= 1'b0;
      rd_value_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      squash_q     <= squash_d;
      hold_q       <= hold_d;
      addr_q       <= addr_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      mask_q       <= mask_d;
      wval_q       <= wval_d;
      rd_q         <= rd_d;
      rd_write_q   <= rd_write_d;
      rd_value_q   <= rd_value_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign data_address_out     = addr_q;
  assign data_read_out        = rd_req_q;
  assign data_write_out       = wr_req_q;
  assign data_write_mask_out  = mask_q;
  assign data_write_value_out = wval_q;
  assign misaligned_out       = misaligned_q;
  assign rd_out               = rd_q;
  assign rd_write_out         = rd_write_q;
  assign rd_value_out         = rd_value_q;

endmodule

// File: tb/tb_rv32_mem_access.sv
// Directed bench for rv32_mem_access: stores, loads, misalignment, stall,
// flush and reset scenarios with hand-computed expectations.
module tb_rv32_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in, flush_in, mem_read_in, mem_write_in;
  logic [1:0]  mem_width_in;
  logic        mem_zero_extend_in, mem_fence_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] result_in, rs2_value_in;
  logic [31:0] data_address_out;
  logic        data_read_out, data_write_out;
  logic [3:0]  data_write_mask_out;
  logic [31:0] data_write_value_out, data_read_value_in;
  logic        data_ready_in, stall_out, misaligned_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;

  int checks = 0;
  int errors = 0;

  rv32_mem_access dut (
    .clk                  (clk),
    .reset                (reset),
    .stall_in             (stall_in),
    .flush_in             (flush_in),
    .mem_read_in          (mem_read_in),
    .mem_write_in         (mem_write_in),
    .mem_width_in         (mem_width_in),
    .mem_zero_extend_in   (mem_zero_extend_in),
    .mem_fence_in         (mem_fence_in),
    .rd_in                (rd_in),
    .rd_write_in          (rd_write_in),
    .result_in            (result_in),
    .rs2_value_in         (rs2_value_in),
    .data_address_out     (data_address_out),
    .data_read_out        (data_read_out),
    .data_write_out       (data_write_out),
    .data_write_mask_out  (data_write_mask_out),
    .data_write_value_out (data_write_value_out),
    .data_read_value_in   (data_read_value_in),
    .data_ready_in        (data_ready_in),
    .stall_out            (stall_out),
    .misaligned_out       (misaligned_out),
    .rd_out               (rd_out),
    .rd_write_out         (rd_write_out),
    .rd_value_out         (rd_value_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic [1:0] width,
                        input logic zext, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rd_we);
    mem_read_in        = rd_en;
    mem_write_in       = wr_en;
    mem_width_in       = width;
    mem_zero_extend_in = zext;
    mem_fence_in       = 1'b0;
    flush_in           = 1'b0;
    result_in          = addr;
    rs2_value_in       = rs2;
    rd_in              = rd;
    rd_write_in        = rd_we;
  endtask

  task automatic bubble();
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    reset              = 1'b1;
    stall_in           = 1'b0;
    data_ready_in      = 1'b0;
    data_read_value_in = 32'h0;
    bubble();
    tick();
    check("reset_rd_value", rd_value_out, 32'h0);
    check("reset_rd_write", rd_write_out, 1'b0);
    check("reset_bus_req", {data_read_out, data_write_out}, 2'b00);
    check("reset_stall", stall_out, 1'b0);
    check("reset_misaligned", misaligned_out, 1'b0);
    reset = 1'b0;
    tick();

    // Word store, ready on the third request cycle.
    set_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd5, 1'b0);
    #1 check("st_w_stall_idle", stall_out, 1'b1);
    check("st_w_no_req_idle", data_write_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_w_write", data_write_out, 1'b1);
      check("st_w_mask", data_write_mask_out, 4'b1111);
      check("st_w_value", data_write_value_out, 32'hDEADBEEF);
      check("st_w_addr", data_address_out, 32'h100);
      if (i == 2) data_ready_in = 1'b1;
      #1 check("st_w_stall_req", stall_out, (i == 2) ? 1'b0 : 1'b1);
    end
    tick();
    bubble();
    data_ready_in = 1'b0;
    check("st_w_req_drop", data_write_out, 1'b0);
    check("st_w_rd_write", rd_write_out, 1'b0);
    check("st_w_rd", rd_out, 5'd5);

    // Byte load from lane 3, sign- then zero-extended.
    data_ready_in      = 1'b1;
    data_read_value_in = 32'h80FFFFFF;
    for (int z = 0; z < 2; z++) begin
      set_op(1'b1, 1'b0, 2'd0, z[0], 32'h103, 32'h0, 5'd7, 1'b1);
      tick();
      check("ld_b_read", data_read_out, 1'b1);
      check("ld_b_addr", data_address_out, 32'h100);
      check("ld_b_stall_ready", stall_out, 1'b0);
      tick();
      bubble();
      check("ld_b_value", rd_value_out, (z == 0) ? 32'hFFFFFF80 : 32'h00000080);
      check("ld_b_rd_write", rd_write_out, 1'b1);
      check("ld_b_read_drop", data_read_out, 1'b0);
    end

    // Half store to the upper half-word.
    set_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, 1'b0);
    tick();
    check("st_h_addr", data_address_out, 32'h200);
    check("st_h_mask", data_write_mask_out, 4'b1100);
    check("st_h_value", data_write_value_out, 32'hABCDABCD);
    tick();
    bubble();
    data_ready_in = 1'b0;

    // Misaligned word load is dropped with a one-cycle flag.
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 5'd4, 1'b1);
    #1 check("mis_stall", stall_out, 1'b0);
    tick();
    bubble();
    check("mis_flag", misaligned_out, 1'b1);
    check("mis_no_read", data_read_out, 1'b0);
    check("mis_rd_write", rd_write_out, 1'b0);
    tick();
    check("mis_flag_clear", misaligned_out, 1'b0);

    // stall_in during the ready cycle parks the data in DONE.
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd9, 1'b1);
    tick();
    data_ready_in      = 1'b1;
    stall_in           = 1'b1;
    data_read_value_in = 32'h55AA55AA;
    #1 check("done_stall_req", stall_out, 1'b1);
    tick();
    data_ready_in      = 1'b0;
    data_read_value_in = 32'h0;
    #1 check("done_stall", stall_out, 1'b1);
    check("done_read_drop", data_read_out, 1'b0);
    check("done_no_wb", rd_write_out, 1'b0);
    tick();
    check("done_stall_held", stall_out, 1'b1);
    stall_in = 1'b0;
    #1 check("done_release", stall_out, 1'b0);
    tick();
    bubble();
    check("done_value", rd_value_out, 32'h55AA55AA);
    check("done_rd_write", rd_write_out, 1'b1);
    check("done_rd", rd_out, 5'd9);

    // Flush while the request is outstanding yields a bubble.
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1);
    tick();
    flush_in = 1'b1;
    #1 check("fl_req_read", data_read_out, 1'b1);
    tick();
    flush_in           = 1'b0;
    data_ready_in      = 1'b1;
    data_read_value_in = 32'h12345678;
    check("fl_still_read", data_read_out, 1'b1);
    tick();
    bubble();
    data_ready_in = 1'b0;
    check("fl_bubble", rd_write_out, 1'b0);
    check("fl_read_drop", data_read_out, 1'b0);

    // Flush in IDLE: no access issued.
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 5'd11, 1'b1);
    flush_in = 1'b1;
    #1 check("fl_idle_stall", stall_out, 1'b0);
    tick();
    bubble();
    check("fl_idle_no_read", data_read_out, 1'b0);
    check("fl_idle_bubble", rd_write_out, 1'b0);

    // Fence passes through as a plain result.
    set_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h77, 32'h0, 5'd3, 1'b1);
    mem_fence_in = 1'b1;
    #1 check("fence_stall", stall_out, 1'b0);
    tick();
    bubble();
    check("fence_value", rd_value_out, 32'h77);
    check("fence_rd_write", rd_write_out, 1'b1);

    // Reset in the middle of a request drops it asynchronously.
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 5'd12, 1'b1);
    tick();
    check("rst_req_read", data_read_out, 1'b1);
    reset = 1'b1;
    #1 check("rst_read_drop", data_read_out, 1'b0);
    check("rst_no_wb", rd_write_out, 1'b0);
    bubble();
    #2 reset = 1'b0;
    tick();
    check("rst_idle_no_read", data_read_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
